// File: rtl/data_mem_responder_if.sv
// Request/response bus between a core (master) and the data memory responder (slave).
interface data_mem_responder_if;
  logic        req;
  logic        wr_en;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        ready;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;

  modport master (
    output req, wr_en, addr, wdata, wmask,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, wr_en, addr, wdata, wmask,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency 64-bit data memory responder with byte-masked writes and
// out-of-range error reporting; one access in flight at a time.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic        r_rvalid;
  logic        r_err;
  logic [63:0] r_rdata;
  logic        r_wr;
  logic [28:0] r_idx;
  logic [63:0] r_wdata;
  logic [7:0]  r_wmask;
  logic [63:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_wr;
  logic [28:0]   w_idx;
  logic [63:0]   w_wdata;
  logic [7:0]    w_wmask;
  logic          w_in_range;
  logic [AW-1:0] w_widx;
  logic          w_unused;

  assign w_accept     = (r_state == IDLE) && bus.req;
  assign w_enter_resp = (w_accept && (LATENCY == 0)) || ((r_state == WAIT) && (r_cnt == '0));

  // With LATENCY=0 the access completes on its own acceptance edge, so the
  // live inputs stand in for the latched copies while still in IDLE.
  assign w_wr    = (r_state == IDLE) ? bus.wr_en      : r_wr;
  assign w_idx   = (r_state == IDLE) ? bus.addr[31:3] : r_idx;
  assign w_wdata = (r_state == IDLE) ? bus.wdata      : r_wdata;
  assign w_wmask = (r_state == IDLE) ? bus.wmask      : r_wmask;

  assign w_in_range = (w_idx >> AW) == '0;
  assign w_widx     = w_idx[AW-1:0];
  assign w_unused   = ^bus.addr[2:0];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wr    <= bus.wr_en;
      r_idx   <= bus.addr[31:3];
      r_wdata <= bus.wdata;
      r_wmask <= bus.wmask;
    end
  end

  // Memory is never reset; a write commits only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_wr && w_in_range) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (w_wmask[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_enter_resp;
      r_err    <= w_enter_resp && !w_in_range;
      r_rdata  <= (w_enter_resp && !w_wr && w_in_range) ? r_mem[w_widx] : '0;
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_ready <= 1'b0;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= RESP;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready  = r_ready;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;
  assign bus.err    = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2/DEPTH=512 instance plus a LATENCY=0/DEPTH=16 instance.
module tb_data_mem_responder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  data_mem_responder_if b ();
  data_mem_responder_if b0 ();

  data_mem_responder #(.DEPTH_WORDS(512), .LATENCY(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rq, input logic wr, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] m);
    if (sel) begin
      b0.req = rq; b0.wr_en = wr; b0.addr = a; b0.wdata = d; b0.wmask = m;
    end else begin
      b.req = rq; b.wr_en = wr; b.addr = a; b.wdata = d; b.wmask = m;
    end
  endtask

  // One full access: accept, scramble inputs, wait (bounded) for rvalid, check timing.
  task automatic access(input bit sel, input int exp_lat, input string tag, input logic wr,
                        input logic [31:0] a, input logic [63:0] d, input logic [7:0] m,
                        output logic [63:0] rd, output logic er);
    int lat;
    int i;
    chk({tag, "_ready_pre"}, 64'(sel ? b0.ready : b.ready), 64'd1);
    drive(sel, 1'b1, wr, a, d, m);
    tick();
    drive(sel, 1'b0, ~wr, 32'hFFFF_FFFF, ~d, ~m);
    i = 1;
    while (!(sel ? b0.rvalid : b.rvalid) && i < 20) begin
      tick();
      i++;
    end
    lat = (sel ? b0.rvalid : b.rvalid) ? i : 0;
    rd  = sel ? b0.rdata : b.rdata;
    er  = sel ? b0.err : b.err;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    tick();
    chk({tag, "_ready_post"}, 64'(sel ? b0.ready : b.ready), 64'd1);
    chk({tag, "_rvalid_post"}, 64'(sel ? b0.rvalid : b.rvalid), 64'd0);
    chk({tag, "_rdata_idle"}, sel ? b0.rdata : b.rdata, 64'd0);
    chk({tag, "_err_idle"}, 64'(sel ? b0.err : b.err), 64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [11:0] rdy_seen;
    logic [11:0] vld_seen;
    logic [63:0] hold_rd;
    logic        any_vld;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    tick(); tick(); tick();
    chk("rst_rvalid", 64'(b.rvalid), 64'd0);
    chk("rst_rdata", b.rdata, 64'd0);
    chk("rst_err", 64'(b.err), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(b.ready), 64'd1);
    chk("post_rst_ready0", 64'(b0.ready), 64'd1);

    // Full write then read-back
    access(1'b0, 3, "wr10", 1'b1, 32'h10, 64'h1122_3344_5566_7788, 8'hFF, rd, er);
    chk("wr10_rdata", rd, 64'd0);
    chk("wr10_err", 64'(er), 64'd0);
    access(1'b0, 3, "rd10", 1'b0, 32'h10, 64'h0, 8'h0, rd, er);
    chk("rd10_rdata", rd, 64'h1122_3344_5566_7788);
    chk("rd10_err", 64'(er), 64'd0);

    // Partial write
    access(1'b0, 3, "pw10", 1'b1, 32'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, rd, er);
    access(1'b0, 3, "rd10b", 1'b0, 32'h10, 64'h0, 8'h0, rd, er);
    chk("rd10b_rdata", rd, 64'h1122_3344_AAAA_AAAA);

    // Out of range: index 512 aliases word 0 when truncated, which must stay intact
    access(1'b0, 3, "wr0", 1'b1, 32'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er);
    access(1'b0, 3, "oor_rd", 1'b0, 32'h1000, 64'h0, 8'h0, rd, er);
    chk("oor_rd_err", 64'(er), 64'd1);
    chk("oor_rd_rdata", rd, 64'd0);
    access(1'b0, 3, "oor_wr", 1'b1, 32'h1000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, rd, er);
    chk("oor_wr_err", 64'(er), 64'd1);
    chk("oor_wr_rdata", rd, 64'd0);
    access(1'b0, 3, "rd0", 1'b0, 32'h7, 64'h0, 8'h0, rd, er);
    chk("rd0_rdata", rd, 64'h0123_4567_89AB_CDEF);
    chk("rd0_err", 64'(er), 64'd0);

    // Zero-mask write
    access(1'b0, 3, "wm0", 1'b1, 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, er);
    chk("wm0_err", 64'(er), 64'd0);
    access(1'b0, 3, "rd10c", 1'b0, 32'h10, 64'h0, 8'h0, rd, er);
    chk("rd10c_rdata", rd, 64'h1122_3344_AAAA_AAAA);

    // Held request: accepts every LATENCY+2 = 4 cycles
    drive(1'b0, 1'b1, 1'b0, 32'h10, 64'h0, 8'h0);
    hold_rd = '0;
    for (int i = 0; i < 12; i++) begin
      rdy_seen[i] = b.ready;
      vld_seen[i] = b.rvalid;
      if (b.rvalid) hold_rd = b.rdata;
      if (i == 11) b.req = 1'b0;
      tick();
    end
    chk("hold_ready_pattern", 64'(rdy_seen), 64'h111);
    chk("hold_rvalid_pattern", 64'(vld_seen), 64'h888);
    chk("hold_rdata", hold_rd, 64'h1122_3344_AAAA_AAAA);
    tick();
    chk("hold_no_queue_ready", 64'(b.ready), 64'd1);
    chk("hold_no_queue_rvalid", 64'(b.rvalid), 64'd0);

    // Write aborted by reset one cycle after acceptance; req held during reset
    access(1'b0, 3, "pre18", 1'b1, 32'h18, 64'h5555_5555_5555_5555, 8'hFF, rd, er);
    drive(1'b0, 1'b1, 1'b1, 32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    tick();
    chk("abort_ready_busy", 64'(b.ready), 64'd0);
    rst = 1'b1;
    tick();
    chk("abort_rvalid", 64'(b.rvalid), 64'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    tick();
    chk("abort_ready_after", 64'(b.ready), 64'd1);
    any_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      any_vld |= b.rvalid;
      tick();
    end
    chk("abort_no_rvalid", 64'(any_vld), 64'd0);
    access(1'b0, 3, "rd18", 1'b0, 32'h18, 64'h0, 8'h0, rd, er);
    chk("rd18_rdata", rd, 64'h5555_5555_5555_5555);

    // LATENCY=0 instance
    access(1'b1, 1, "l0_wr", 1'b1, 32'h8, 64'hCAFE_F00D_1234_5678, 8'hFF, rd, er);
    chk("l0_wr_err", 64'(er), 64'd0);
    access(1'b1, 1, "l0_rd", 1'b0, 32'h8, 64'h0, 8'h0, rd, er);
    chk("l0_rd_rdata", rd, 64'hCAFE_F00D_1234_5678);
    access(1'b1, 1, "l0_oor", 1'b0, 32'h80, 64'h0, 8'h0, rd, er);
    chk("l0_oor_err", 64'(er), 64'd1);
    chk("l0_oor_rdata", rd, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 512, giving the number of 64-bit memory words (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait cycles between request acceptance and response (0..15).
REQ-003 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  1  core requests an access this cycle.
REQ-007 wr_en  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  32  byte address; addr[2:0] ignored, word index = addr[31:3].
REQ-009 wdata  input  64  write data; byte i = wdata[8i+7:8i].
REQ-010 wmask  input  8  byte enables; bit i enables byte i.
REQ-011 ready  output  1  responder can accept a request this cycle.
REQ-012 rvalid  output  1  one-cycle response strobe for reads and writes.
REQ-013 rdata  output  64  read data, valid only while rvalid=1.
REQ-014 err  output  1  out-of-range access flag, valid only while rvalid=1.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 ready SHALL be 1 only in IDLE; a request is accepted on an edge where req=1 and ready=1.
REQ-017 On acceptance, wr_en, the word index, wdata and wmask SHALL be latched; later input changes SHALL have no effect on that access.
REQ-018 Transition SHALL be IDLE->WAIT on acceptance when LATENCY>0 (wait counter loaded with LATENCY-1), and IDLE->RESP directly when LATENCY=0.
REQ-019 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL move to RESP on the edge where the counter is 0.
REQ-020 rvalid SHALL be 1 only in RESP, exactly LATENCY+1 cycles after the acceptance edge, for exactly one cycle.
REQ-021 RESP->IDLE SHALL be unconditional; ready SHALL be 1 in the cycle after rvalid.
REQ-022 req while ready=0 SHALL be ignored and not queued.
REQ-023 Out-of-range means word index >= DEPTH_WORDS; an out-of-range access SHALL still follow the full timing, with err=1 and rdata=0 in RESP.
REQ-024 An out-of-range write SHALL leave memory unmodified.
REQ-025 A read response SHALL carry mem[index] in rdata.
REQ-026 An in-range write SHALL update only the bytes whose latched wmask bit is 1.
REQ-027 A write SHALL commit on the edge entering RESP; a write response SHALL have rdata=0 and err=0.
REQ-028 wmask=0 on a write SHALL produce a normal response with no memory change.
REQ-029 rdata and err SHALL be 0 whenever rvalid=0.

Reset
REQ-030 While rst=1 at an edge, the FSM SHALL go to IDLE, the wait counter to 0, and rvalid, err and rdata to 0.
REQ-031 ready SHALL be 1 in the first cycle after reset deasserts.
REQ-032 rst asserted mid-access SHALL abort the access with no response.
REQ-033 A write aborted by rst before its commit edge SHALL NOT modify memory.
REQ-034 Memory contents SHALL NOT be cleared by reset.
REQ-035 req sampled in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-036 LATENCY=2: write addr=0x10, wdata=0x1122334455667788, wmask=0xFF -> rvalid pulses exactly 3 cycles after acceptance; read addr=0x10 -> rdata=0x1122334455667788, err=0.
REQ-037 Partial write to addr=0x10, wdata=0xAAAAAAAAAAAAAAAA, wmask=0x0F, then read -> rdata=0x11223344AAAAAAAA.
REQ-038 DEPTH_WORDS=512: read addr=0x1000 -> rvalid with err=1, rdata=0; write to the same address then read addr=0x0 -> mem[0] unchanged.
REQ-039 Hold req=1 continuously -> ready low during WAIT/RESP, back-to-back accepts spaced LATENCY+2 cycles apart, no queued extra accesses.
REQ-040 Accept write addr=0x18, data 0xFF..FF, and assert rst one cycle later -> no rvalid, ready=1 after reset, and a read of 0x18 returns the prior contents.
REQ-041 LATENCY=0 build: accept read -> rvalid on the next cycle, ready high the cycle after that.
